// File: rtl/sync_fifo_flags_if.sv
// Handshake/status bundle between a producer/consumer and the sync_fifo_flags buffer.
// The master modport is the client side. The slave modport is the FIFO itself.
interface sync_fifo_flags_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 5
);
    logic [DWIDTH-1:0] data_in;
    logic              wr_en;
    logic              rd_en;
    logic              clr_err;
    logic [DWIDTH-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AWIDTH:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output data_in, wr_en, rd_en, clr_err,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  data_in, wr_en, rd_en, clr_err,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable first-word-fall-through read mode.
module sync_fifo_flags #(
    parameter int AWIDTH   = 8,
    parameter int DWIDTH   = 5,
    parameter int AF_LEVEL = (2 ** AWIDTH) - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_fifo_flags_if.slave  bus
);
    localparam int              DEPTH   = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_C    = (AWIDTH + 1)'(AF_LEVEL);
    localparam logic [AWIDTH:0] AE_C    = (AWIDTH + 1)'(AE_LEVEL);
    localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH - 1){1'b0}}, 1'b1};

    logic [DWIDTH-1:0] mem_r [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_r;
    logic [AWIDTH-1:0] rd_ptr_r;
    logic [AWIDTH:0]   count_r;
    logic [AWIDTH:0]   count_nxt_s;
    logic              full_r;
    logic              empty_r;
    logic              almost_full_r;
    logic              almost_empty_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              wr_acc_s;
    logic              rd_acc_s;

    // Accept decode and next occupancy; the pointers wrap naturally, count tells full from empty.
    always_comb begin
        wr_acc_s    = bus.wr_en && !full_r;
        rd_acc_s    = bus.rd_en && !empty_r;
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and status flags; flags are registered from the next count so they track count exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r       <= {AWIDTH{1'b0}};
            rd_ptr_r       <= {AWIDTH{1'b0}};
            count_r        <= {(AWIDTH + 1){1'b0}};
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r        <= count_nxt_s;
            full_r         <= (count_nxt_s == DEPTH_C);
            empty_r        <= (count_nxt_s == {(AWIDTH + 1){1'b0}});
            almost_full_r  <= (count_nxt_s >= AF_C);
            almost_empty_r <= (count_nxt_s <= AE_C);
        end
    end

    // Sticky error flags; a new error event at the same edge as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (bus.wr_en && full_r) begin
                overflow_r <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (bus.rd_en && empty_r) begin
                underflow_r <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    // Storage array, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= bus.data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic [DWIDTH-1:0] head_s;

            // Head word shown directly; forced to zero while empty so reset reads back as 0.
            always_comb begin
                head_s = {DWIDTH{1'b0}};
                if (!empty_r) begin
                    head_s = mem_r[rd_ptr_r];
                end else begin
                    head_s = {DWIDTH{1'b0}};
                end
            end

            assign bus.data_out = head_s;
        end else begin : g_std
            logic [DWIDTH-1:0] data_out_r;

            // Registered read port: loads only on an accepted read, otherwise holds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out_r <= {DWIDTH{1'b0}};
                end else if (rd_acc_s) begin
                    data_out_r <= mem_r[rd_ptr_r];
                end else begin
                    data_out_r <= data_out_r;
                end
            end

            assign bus.data_out = data_out_r;
        end
    endgenerate

    assign bus.count        = count_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one standard-read and one FWFT instance
// (AWIDTH=3, DWIDTH=5, AF_LEVEL=6, AE_LEVEL=1) sharing clock and reset.
module tb_sync_fifo_flags;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    logic [4:0] exp_rd;
    logic [4:0] exp_wr;

    sync_fifo_flags_if #(.AWIDTH(3), .DWIDTH(5)) b0 ();
    sync_fifo_flags_if #(.AWIDTH(3), .DWIDTH(5)) b1 ();

    sync_fifo_flags #(.AWIDTH(3), .DWIDTH(5), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    sync_fifo_flags #(.AWIDTH(3), .DWIDTH(5), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check count plus the four level flags of the standard-read instance.
    task automatic chk_lvl(input string tag, input int c);
        chk({tag, ".count"}, 32'(b0.count), 32'(c));
        chk({tag, ".empty"}, 32'(b0.empty), 32'(c == 0));
        chk({tag, ".full"}, 32'(b0.full), 32'(c == 8));
        chk({tag, ".af"}, 32'(b0.almost_full), 32'(c >= 6));
        chk({tag, ".ae"}, 32'(b0.almost_empty), 32'(c <= 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        {b0.data_in, b0.wr_en, b0.rd_en, b0.clr_err} = 8'h00;
        {b1.data_in, b1.wr_en, b1.rd_en, b1.clr_err} = 8'h00;
        tick();
        tick();

        // Reset state
        chk_lvl("rst", 0);
        chk("rst.ovf", 32'(b0.overflow), 32'd0);
        chk("rst.udf", 32'(b0.underflow), 32'd0);
        chk("rst.dout", 32'(b0.data_out), 32'd0);
        chk("rst.dout1", 32'(b1.data_out), 32'd0);
        chk("rst.empty1", 32'(b1.empty), 32'd1);
        rst_n = 1'b1;
        tick();
        chk_lvl("idle", 0);

        // Three writes then three reads, standard mode
        b0.wr_en = 1'b1;
        b0.data_in = 5'h1F; tick(); chk_lvl("w1", 1);
        b0.data_in = 5'h1E; tick(); chk_lvl("w2", 2);
        b0.data_in = 5'h1D; tick(); chk_lvl("w3", 3);
        b0.wr_en = 1'b0;
        b0.rd_en = 1'b1;
        tick(); chk("r1.dout", 32'(b0.data_out), 32'h1F); chk_lvl("r1", 2);
        tick(); chk("r2.dout", 32'(b0.data_out), 32'h1E); chk_lvl("r2", 1);
        tick(); chk("r3.dout", 32'(b0.data_out), 32'h1D); chk_lvl("r3", 0);
        b0.rd_en = 1'b0;
        tick(); chk("r3.hold", 32'(b0.data_out), 32'h1D);

        // Fill to capacity, then one write too many
        b0.wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b0.data_in = 5'(i);
            tick();
            chk_lvl("fill", i + 1);
        end
        b0.data_in = 5'h15;
        tick();
        chk_lvl("ovw", 8);
        chk("ovw.ovf", 32'(b0.overflow), 32'd1);
        b0.wr_en = 1'b0;
        b0.rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain.dout", 32'(b0.data_out), 32'(i));
            chk_lvl("drain", 7 - i);
        end
        b0.rd_en = 1'b0;
        tick();
        chk("drain.hold", 32'(b0.data_out), 32'h07);
        chk("drain.udf", 32'(b0.underflow), 32'd0);

        // Pointer wrap: prime 4 words, then alternate write/read around the ring
        b0.wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b0.data_in = 5'(8 + i);
            tick();
        end
        chk_lvl("prime", 4);
        exp_rd = 5'h08;
        exp_wr = 5'h0C;
        for (int k = 0; k < 20; k++) begin
            b0.wr_en = ((k % 2) == 0);
            b0.rd_en = ((k % 2) == 1);
            b0.data_in = exp_wr;
            tick();
            if ((k % 2) == 0) begin
                exp_wr = exp_wr + 5'd1;
                chk("wrap.cnt", 32'(b0.count), 32'd5);
            end else begin
                chk("wrap.dout", 32'(b0.data_out), 32'(exp_rd));
                exp_rd = exp_rd + 5'd1;
                chk("wrap.cnt", 32'(b0.count), 32'd4);
            end
        end
        b0.wr_en = 1'b0;
        b0.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wdrain.dout", 32'(b0.data_out), 32'(exp_rd));
            exp_rd = exp_rd + 5'd1;
        end
        b0.rd_en = 1'b0;
        chk_lvl("wdrain", 0);

        // Clear the overflow left over from the fill test
        b0.clr_err = 1'b1;
        tick();
        b0.clr_err = 1'b0;
        chk("clr.ovf", 32'(b0.overflow), 32'd0);

        // Simultaneous read/write at full: read wins, write dropped
        b0.wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b0.data_in = 5'(i);
            tick();
        end
        chk_lvl("full2", 8);
        b0.rd_en = 1'b1;
        b0.data_in = 5'h1A;
        tick();
        chk_lvl("rwfull", 7);
        chk("rwfull.ovf", 32'(b0.overflow), 32'd1);
        chk("rwfull.dout", 32'(b0.data_out), 32'h00);
        b0.wr_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("rwdrain.dout", 32'(b0.data_out), 32'(i));
        end
        chk_lvl("rwdrain", 0);

        // Simultaneous read/write at empty: write wins, read dropped, data_out holds
        b0.wr_en = 1'b1;
        b0.data_in = 5'h11;
        tick();
        chk_lvl("rwempty", 1);
        chk("rwempty.udf", 32'(b0.underflow), 32'd1);
        chk("rwempty.dout", 32'(b0.data_out), 32'h07);
        b0.wr_en = 1'b0;
        b0.rd_en = 1'b0;

        // Error event coinciding with clr_err keeps the flag set
        b0.clr_err = 1'b1;
        b0.rd_en = 1'b1;
        tick();
        chk("clrrace.cnt", 32'(b0.count), 32'd0);
        chk("clrrace.dout", 32'(b0.data_out), 32'h11);
        tick();
        chk("clrrace.udf", 32'(b0.underflow), 32'd1);
        chk("clrrace.ovf", 32'(b0.overflow), 32'd0);
        b0.rd_en = 1'b0;
        tick();
        b0.clr_err = 1'b0;
        chk("clr2.udf", 32'(b0.underflow), 32'd0);

        // FWFT: head word visible without rd_en
        b1.wr_en = 1'b1;
        b1.data_in = 5'h0A;
        tick();
        b1.wr_en = 1'b0;
        chk("fw.empty", 32'(b1.empty), 32'd0);
        chk("fw.dout", 32'(b1.data_out), 32'h0A);
        chk("fw.cnt", 32'(b1.count), 32'd1);
        tick();
        chk("fw.hold", 32'(b1.data_out), 32'h0A);
        b1.rd_en = 1'b1;
        tick();
        chk("fw.pop.empty", 32'(b1.empty), 32'd1);
        chk("fw.pop.cnt", 32'(b1.count), 32'd0);
        chk("fw.pop.udf", 32'(b1.underflow), 32'd0);
        tick();
        chk("fw.udf", 32'(b1.underflow), 32'd1);
        b1.rd_en = 1'b0;

        // FWFT: second word appears after popping the first
        b1.wr_en = 1'b1;
        b1.data_in = 5'h03; tick();
        b1.data_in = 5'h04; tick();
        b1.wr_en = 1'b0;
        chk("fw2.head", 32'(b1.data_out), 32'h03);
        b1.rd_en = 1'b1;
        tick();
        b1.rd_en = 1'b0;
        chk("fw2.next", 32'(b1.data_out), 32'h04);
        chk("fw2.cnt", 32'(b1.count), 32'd1);

        // Asynchronous reset mid-traffic discards stored words
        b0.wr_en = 1'b1;
        b0.data_in = 5'h09;
        tick();
        b0.wr_en = 1'b0;
        chk("pre.cnt", 32'(b0.count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_lvl("arst", 0);
        chk("arst.cnt1", 32'(b1.count), 32'd0);
        chk("arst.udf1", 32'(b1.underflow), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_lvl("post", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
